// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch/decode constants and fetch FSM state encoding
package fetch_stage_pkg;

  localparam int unsigned ADDR_W_DEFAULT   = 7;
  localparam int unsigned PC_W_DEFAULT     = 32;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with +4 adder, aligned redirect mux and range check
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned       PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              load_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              next_out_of_range
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_cand;

  always_comb begin
    pc_plus4          = pc_q + PC_W'(4);
    pc_cand           = redirect ? (redirect_pc & ~PC_W'(3)) : pc_plus4;
    pc_d              = load_en ? pc_cand : pc_q;
    // Candidate is checked even when not loaded, so HALT can vet a redirect target.
    next_out_of_range = |pc_cand[PC_W-1:ADDR_W+2];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q[ADDR_W+1:2];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: BOOT/RUN/HALT FSM and IF/ID register
// Optional perf_fetched/perf_bubbles counters under FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned     PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_wre,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [31:0]       ifid_instr,
  output logic [PC_W-1:0]   ifid_pc4,
  output logic              ifid_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  fetch_state_e    state_q, state_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            pc_load;
  logic            bubble;
  logic [PC_W-1:0] pc_plus4;
  logic            next_oor;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock             (clock),
    .reset             (reset),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .load_en           (pc_load),
    .imem_addr         (imem_addr),
    .pc_plus4          (pc_plus4),
    .next_out_of_range (next_oor)
  );

  always_comb begin
    state_d      = state_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    pc_load      = 1'b0;
    bubble       = 1'b0;
    case (state_q)
      ST_BOOT: begin
        bubble  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_load = 1'b1;
          bubble  = 1'b1;
          if (next_oor) state_d = ST_HALT;
        end else if (!stall) begin
          // imem_data is only consumed here, so X elsewhere cannot leak into IF/ID.
          pc_load      = 1'b1;
          ifid_instr_d = imem_data;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          if (next_oor) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        bubble = 1'b1;
        if (redirect && !next_oor) begin
          pc_load = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: begin
        bubble  = 1'b1;
        state_d = ST_BOOT;
      end
    endcase
    if (bubble) begin
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_wre   = 1'b1;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic        fetch_adv;

  always_comb begin
    fetch_adv      = (state_q == ST_RUN) && !redirect && !stall;
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (fetch_adv && (perf_fetched_q != 32'hFFFF_FFFF)) perf_fetched_d = perf_fetched_q + 32'd1;
    if (bubble && (perf_bubbles_q != 32'hFFFF_FFFF)) perf_bubbles_d = perf_bubbles_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  imem_addr;
  logic        imem_wre;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clock = ~clock;
  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_wre    (imem_wre),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  // Behavioural model: mode, byte PC, IF/ID contents, event counters.
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam logic [31:0] MEM_BYTES = 32'd512;

  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4, m_fetched, m_bubbles;
  logic        m_valid;
  logic [31:0] tgt;
  logic [31:0] seq;

  assign tgt = redirect_pc - (redirect_pc % 32'd4);
  assign seq = m_pc + 32'd4;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode    <= M_BOOT;
      m_pc      <= 32'd0;
      m_instr   <= 32'd0;
      m_pc4     <= 32'd0;
      m_valid   <= 1'b0;
      m_fetched <= 32'd0;
      m_bubbles <= 32'd0;
    end else begin
      case (m_mode)
        M_BOOT: begin
          m_instr   <= 32'd0;
          m_valid   <= 1'b0;
          m_bubbles <= (m_bubbles == 32'hFFFF_FFFF) ? m_bubbles : m_bubbles + 1;
          m_mode    <= M_RUN;
        end
        M_RUN: begin
          if (redirect) begin
            m_pc      <= tgt;
            m_instr   <= 32'd0;
            m_valid   <= 1'b0;
            m_bubbles <= (m_bubbles == 32'hFFFF_FFFF) ? m_bubbles : m_bubbles + 1;
            if (tgt >= MEM_BYTES) m_mode <= M_HALT;
          end else if (!stall) begin
            m_instr   <= mem[m_pc[8:2]];
            m_pc4     <= seq;
            m_valid   <= 1'b1;
            m_pc      <= seq;
            m_fetched <= (m_fetched == 32'hFFFF_FFFF) ? m_fetched : m_fetched + 1;
            if (seq >= MEM_BYTES) m_mode <= M_HALT;
          end
        end
        default: begin
          m_instr   <= 32'd0;
          m_valid   <= 1'b0;
          m_bubbles <= (m_bubbles == 32'hFFFF_FFFF) ? m_bubbles : m_bubbles + 1;
          if (redirect && tgt < MEM_BYTES) begin
            m_pc   <= tgt;
            m_mode <= M_RUN;
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_pc[8:2]));
      chk("imem_wre", 32'(imem_wre), 32'd1);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc4", ifid_pc4, m_pc4);
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("halted", 32'(halted), 32'(m_mode == M_HALT));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[3]  = 32'h2008_0004;
    mem[4]  = 32'h2009_0003;
    mem[7]  = 32'h1500_0003;
    mem[16] = 32'hAC08_0000;

    repeat (2) tick();
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
    chk("rst_pc4", ifid_pc4, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    tick();
    chk("boot_bubble", 32'(ifid_valid), 32'd0);
    repeat (4) tick();
    chk("word3_instr", ifid_instr, 32'h2008_0004);
    chk("word3_pc4", ifid_pc4, 32'h10);
    chk("word3_valid", 32'(ifid_valid), 32'd1);
    tick();
    chk("word4_instr", ifid_instr, 32'h2009_0003);
    repeat (3) tick();
    chk("word7_instr", ifid_instr, 32'h1500_0003);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", ifid_instr, 32'h1500_0003);
      chk("stall_pc4", ifid_pc4, 32'h20);
      chk("stall_addr", 32'(imem_addr), 32'd8);
    end
    stall = 1'b0;
    tick();
    chk("after_stall_pc4", ifid_pc4, 32'h24);

    redirect = 1'b1; redirect_pc = 32'h2E; stall = 1'b1;
    tick();
    chk("redir_addr", 32'(imem_addr), 32'd11);
    chk("redir_valid", 32'(ifid_valid), 32'd0);
    chk("redir_instr", ifid_instr, 32'd0);
    chk("redir_pc4_hold", ifid_pc4, 32'h24);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("word11_instr", ifid_instr, mem[11]);
    chk("word11_pc4", ifid_pc4, 32'h30);

    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom % 4) == 0;
      redirect    = ($urandom % 10) == 0;
      redirect_pc = (($urandom % 8) == 0) ? $urandom : 32'($urandom_range(0, 511));
      tick();
    end

    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h1F0;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    chk("pre_halt", 32'(halted), 32'd0);
    tick();
    chk("word127_instr", ifid_instr, mem[127]);
    chk("word127_valid", 32'(ifid_valid), 32'd1);
    chk("halt_enter", 32'(halted), 32'd1);
    tick();
    chk("halt_bubble", 32'(ifid_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h400; stall = 1'b1;
    tick();
    chk("halt_oor_redir", 32'(halted), 32'd1);
    redirect_pc = 32'h40; stall = 1'b0;
    tick();
    chk("halt_exit", 32'(halted), 32'd0);
    chk("halt_exit_bubble", 32'(ifid_valid), 32'd0);
    redirect = 1'b0;
    tick();
    chk("word16_instr", ifid_instr, 32'hAC08_0000);
    chk("word16_pc4", ifid_pc4, 32'h44);

    redirect = 1'b1; redirect_pc = 32'h30;
    tick();
    redirect = 1'b0; stall = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_valid", 32'(ifid_valid), 32'd0);
    chk("mid_rst_instr", ifid_instr, 32'd0);
    chk("mid_rst_pc4", ifid_pc4, 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    tick();
    reset = 1'b0; stall = 1'b0;
    tick();
    chk("reboot_bubble", 32'(ifid_valid), 32'd0);
    repeat (5) tick();
    chk("reboot_word4", ifid_instr, 32'h2009_0003);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_5", perf_fetched, 32'd5);
    chk("perf_bubbles_2", perf_bubbles, 32'd2);
`endif
    repeat (3) tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
